frame_lock_checker: RTL and testbench

- Parametrised receive-side word-alignment and link-quality checker. It generalises the fixed 40-bit ETROC2 receiver alignment and data-extract stage.
- Consumes raw deserialised words.
- Hunts for the sync field by commanding bit-slip offsets to the deserializer.
- Declares lock with hysteresis and outputs aligned words.
- Keeps saturating link-quality counters and a windowed good-word rate.
- Sits between the deserializer and the event/record checkers in the receive chain.

---
 rtl/frame_lock_checker_pkg.sv | 32 +++
 rtl/frame_lock_checker_if.sv | 34 +++
 rtl/frame_lock_checker_sat_counter.sv | 25 ++
 rtl/frame_lock_checker.sv | 214 +++++++++++++++++++++
 tb/tb_frame_lock_checker.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_lock_checker_pkg.sv
// Shared types and constants for the frame lock checker: FSM encoding,
// default sync field, counter event strobes and a constant clog2.
package frame_lock_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH        = 40;
  localparam logic [39:0] DEF_SYNC_MASK    = 40'hFF_0000_0000;
  localparam logic [39:0] DEF_SYNC_PATTERN = 40'h3C_0000_0000;

  typedef struct packed {
    logic frame_err;
    logic unlock;
    logic slip;
  } cnt_evt_t;

  // Bits needed to address v distinct values; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/frame_lock_checker_if.sv
// Word stream, control and status bundle between the deserializer-side
// driver and the frame lock checker.
interface frame_lock_checker_if #(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned AW          = frame_lock_checker_pkg::clog2(WIDTH),
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned WINDOW_LOG2 = 6
);
  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 manual_en;
  logic [AW-1:0]        manual_addr;
  logic                 clr_counters;
  logic [AW-1:0]        word_addr;
  logic                 aligned;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [CNT_W-1:0]     frame_error_count;
  logic [CNT_W-1:0]     unlock_count;
  logic [CNT_W-1:0]     slip_count;
  logic [WINDOW_LOG2:0] good_rate;

  modport master (
    output din, din_valid, manual_en, manual_addr, clr_counters,
    input  word_addr, aligned, dout, dout_valid,
           frame_error_count, unlock_count, slip_count, good_rate
  );

  modport slave (
    input  din, din_valid, manual_en, manual_addr, clr_counters,
    output word_addr, aligned, dout, dout_valid,
           frame_error_count, unlock_count, slip_count, good_rate
  );
endinterface

// File: rtl/frame_lock_checker_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module frame_lock_checker_sat_counter #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/frame_lock_checker.sv
// Word-alignment hunter with lock hysteresis, bit-slip control, aligned
// data output and link-quality statistics.
module frame_lock_checker
  import frame_lock_checker_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_MASK    = WIDTH'(DEF_SYNC_MASK),
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC_PATTERN),
  parameter int unsigned      LOCK_CNT     = 8,
  parameter int unsigned      UNLOCK_CNT   = 4,
  parameter int unsigned      SLIP_WAIT    = 2 * WIDTH,
  parameter int unsigned      SETTLE       = 4,
  parameter int unsigned      WINDOW_LOG2  = 6,
  parameter int unsigned      CNT_W        = 20
) (
  input  logic               clk,
  input  logic               reset,
  frame_lock_checker_if.slave bus
);
  localparam int unsigned AW     = clog2(WIDTH);
  localparam int unsigned MISS_W = clog2(SLIP_WAIT + 1);
  localparam int unsigned SET_W  = clog2(SETTLE + 1);
  localparam int unsigned WL     = WINDOW_LOG2;
  localparam logic [7:0]        LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0]        UNLOCK_N = 8'(UNLOCK_CNT);
  localparam logic [MISS_W-1:0] SLIP_N   = MISS_W'(SLIP_WAIT);
  localparam logic [SET_W-1:0]  SET_N    = SET_W'(SETTLE);
  localparam logic [AW-1:0]     ADDR_MAX = AW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        run_q, run_d, bad_q, bad_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              man_en_q;
  logic [AW-1:0]     man_addr_q;
  logic              aligned_q, aligned_d, dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WL-1:0]     win_cnt_q, win_cnt_d;
  logic [WL:0]       win_good_q, win_good_d, good_rate_q, good_rate_d, good_sum_c;
  cnt_evt_t          evt_c;
  logic              match_c, manual_load_c;

  assign match_c       = bus.din_valid && ((bus.din & SYNC_MASK) == SYNC_PATTERN);
  assign manual_load_c = bus.manual_en && (!man_en_q || (bus.manual_addr != man_addr_q));

  // State register plus the FSM's private counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      addr_q     <= '0;
      run_q      <= '0;
      bad_q      <= '0;
      miss_q     <= '0;
      settle_q   <= '0;
      man_en_q   <= 1'b0;
      man_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      run_q      <= run_d;
      bad_q      <= bad_d;
      miss_q     <= miss_d;
      settle_q   <= settle_d;
      man_en_q   <= bus.manual_en;
      man_addr_q <= bus.manual_addr;
    end
  end

  // Next-state: manual reload has priority; otherwise advance on valid words only.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    run_d    = run_q;
    bad_d    = bad_q;
    miss_d   = miss_q;
    settle_d = settle_q;
    evt_c    = '0;
    if (manual_load_c) begin
      state_d  = ST_SETTLE;
      addr_d   = bus.manual_addr;
      run_d    = '0;
      bad_d    = '0;
      miss_d   = '0;
      settle_d = '0;
    end else if (bus.din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (match_c) begin
            if (LOCK_N == 8'd1) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
              miss_d  = '0;
            end else begin
              state_d = ST_VERIFY;
              run_d   = 8'd1;
            end
          end else if (miss_q + MISS_W'(1) >= SLIP_N) begin
            if (!bus.manual_en) begin
              addr_d     = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
              evt_c.slip = 1'b1;
              miss_d     = '0;
              settle_d   = '0;
              state_d    = ST_SETTLE;
            end else begin
              miss_d = SLIP_N;
            end
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_q + SET_W'(1) >= SET_N) begin
            settle_d = '0;
            state_d  = ST_HUNT;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        ST_VERIFY: begin
          if (!match_c) begin
            state_d = ST_HUNT;
            run_d   = '0;
          end else if (run_q + 8'd1 >= LOCK_N) begin
            state_d = ST_LOCKED;
            run_d   = '0;
            bad_d   = '0;
            miss_d  = '0;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        default: begin
          if (match_c) begin
            bad_d = '0;
          end else begin
            evt_c.frame_err = 1'b1;
            if (bad_q + 8'd1 >= UNLOCK_N) begin
              state_d      = ST_HUNT;
              bad_d        = '0;
              miss_d       = '0;
              evt_c.unlock = 1'b1;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Output and window next values; the window closes on its 2^WL-th valid word.
  always_comb begin
    aligned_d    = (state_d == ST_LOCKED);
    dout_valid_d = bus.din_valid && aligned_q;
    dout_d       = bus.din_valid ? bus.din : dout_q;
    win_cnt_d    = win_cnt_q;
    win_good_d   = win_good_q;
    good_rate_d  = good_rate_q;
    good_sum_c   = win_good_q + (WL+1)'(match_c);
    if (bus.clr_counters) begin
      win_cnt_d   = '0;
      win_good_d  = '0;
      good_rate_d = '0;
    end else if (bus.din_valid) begin
      win_cnt_d = win_cnt_q + WL'(1);
      if (win_cnt_q == '1) begin
        good_rate_d = good_sum_c;
        win_good_d  = '0;
      end else begin
        win_good_d = good_sum_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aligned_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      win_cnt_q    <= '0;
      win_good_q   <= '0;
      good_rate_q  <= '0;
    end else begin
      aligned_q    <= aligned_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      win_cnt_q    <= win_cnt_d;
      win_good_q   <= win_good_d;
      good_rate_q  <= good_rate_d;
    end
  end

  frame_lock_checker_sat_counter #(.W(CNT_W)) u_frame_err_cnt (
    .clk(clk), .reset(reset), .inc_i(evt_c.frame_err), .clr_i(bus.clr_counters),
    .cnt_o(bus.frame_error_count)
  );

  frame_lock_checker_sat_counter #(.W(CNT_W)) u_unlock_cnt (
    .clk(clk), .reset(reset), .inc_i(evt_c.unlock), .clr_i(bus.clr_counters),
    .cnt_o(bus.unlock_count)
  );

  frame_lock_checker_sat_counter #(.W(CNT_W)) u_slip_cnt (
    .clk(clk), .reset(reset), .inc_i(evt_c.slip), .clr_i(bus.clr_counters),
    .cnt_o(bus.slip_count)
  );

  assign bus.word_addr  = addr_q;
  assign bus.aligned    = aligned_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.good_rate  = good_rate_q;
endmodule

// File: tb/tb_frame_lock_checker.sv
// Scenario bench for frame_lock_checker: a scoreboard queue carries expected
// aligned words; a narrow-counter twin instance exercises saturation.
module tb_frame_lock_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [39:0] din = '0;
  logic        din_valid = 1'b0;
  logic        manual_en = 1'b0;
  logic [5:0]  manual_addr = '0;
  logic        clr_counters = 1'b0;

  int checks = 0;
  int fails  = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  frame_lock_checker_if #(.WIDTH(40), .CNT_W(20), .WINDOW_LOG2(6)) ifm ();
  frame_lock_checker_if #(.WIDTH(40), .CNT_W(3),  .WINDOW_LOG2(6)) ifs ();

  assign ifm.din = din;                  assign ifs.din = din;
  assign ifm.din_valid = din_valid;      assign ifs.din_valid = din_valid;
  assign ifm.manual_en = manual_en;      assign ifs.manual_en = manual_en;
  assign ifm.manual_addr = manual_addr;  assign ifs.manual_addr = manual_addr;
  assign ifm.clr_counters = clr_counters; assign ifs.clr_counters = clr_counters;

  frame_lock_checker #(.CNT_W(20)) u_dut (.clk(clk), .reset(reset), .bus(ifm));
  frame_lock_checker #(.CNT_W(3))  u_sat (.clk(clk), .reset(reset), .bus(ifs));

  // Scoreboard: every aligned output word must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && ifm.dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dout_unexpected: got dout=%h with no word expected", ifm.dout);
      end else begin
        logic [39:0] w;
        w = exp_q.pop_front();
        if (ifm.dout !== w) begin
          fails++;
          $display("FAIL dout_data: got %h expected %h", ifm.dout, w);
        end
      end
    end
  end

  function automatic logic [39:0] mk_word(input bit good);
    logic [31:0] r;
    r = $urandom;
    return {(good ? 8'h3C : 8'hC3), r};
  endfunction

  task automatic send(input logic [39:0] w, input bit exp_out);
    din = w;
    din_valid = 1'b1;
    if (exp_out) exp_q.push_back(w);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_dut();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words never appeared, expected 0", exp_q.size());
    end
    exp_q.delete();
    reset = 1'b0; manual_en = 1'b0; clr_counters = 1'b0; din_valid = 1'b0;
    idle(2);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if ({ifm.word_addr, ifm.aligned, ifm.dout, ifm.dout_valid, ifm.frame_error_count,
         ifm.unlock_count, ifm.slip_count, ifm.good_rate} !== '0) begin
      fails++;
      $display("FAIL reset_values: addr=%0d aligned=%b dout=%h dv=%b fe=%0d un=%0d sl=%0d gr=%0d, expected all 0",
               ifm.word_addr, ifm.aligned, ifm.dout, ifm.dout_valid, ifm.frame_error_count,
               ifm.unlock_count, ifm.slip_count, ifm.good_rate);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lock_offset0();
    for (int i = 0; i < 8; i++) begin
      send(mk_word(1), 1'b0);
      checks++;
      if (ifm.aligned !== (i == 7)) begin
        fails++;
        $display("FAIL lock_timing word %0d: aligned=%b expected %b", i, ifm.aligned, (i == 7));
      end
    end
    checks++;
    if (ifm.word_addr !== 6'd0 || ifm.slip_count !== 20'd0) begin
      fails++;
      $display("FAIL lock_offset0: addr=%0d slips=%0d expected 0/0", ifm.word_addr, ifm.slip_count);
    end
    for (int i = 0; i < 4; i++) send(mk_word(1), 1'b1);
  endtask

  task automatic test_unlock();
    logic [0:7] pat;
    pat = 8'b00010000;
    for (int i = 0; i < 8; i++) begin
      send(mk_word(pat[i]), 1'b1);
      checks++;
      if (ifm.aligned !== (i != 7)) begin
        fails++;
        $display("FAIL unlock_hyst word %0d: aligned=%b expected %b", i, ifm.aligned, (i != 7));
      end
    end
    checks++;
    if (ifm.frame_error_count !== 20'd7 || ifm.unlock_count !== 20'd1 || ifm.word_addr !== 6'd0) begin
      fails++;
      $display("FAIL unlock_counts: fe=%0d unlocks=%0d addr=%0d expected 7/1/0",
               ifm.frame_error_count, ifm.unlock_count, ifm.word_addr);
    end
    send(mk_word(0), 1'b0);
  endtask

  task automatic test_window();
    for (int i = 0; i < 8; i++) send(mk_word(1), 1'b0);
    checks++;
    if (ifm.aligned !== 1'b1) begin
      fails++;
      $display("FAIL relock: aligned=%b expected 1", ifm.aligned);
    end
    clr_counters = 1'b1;
    idle(1);
    clr_counters = 1'b0;
    checks++;
    if ({ifm.frame_error_count, ifm.unlock_count, ifm.slip_count, ifm.good_rate} !== '0) begin
      fails++;
      $display("FAIL clr_counters: fe=%0d un=%0d sl=%0d gr=%0d expected all 0",
               ifm.frame_error_count, ifm.unlock_count, ifm.slip_count, ifm.good_rate);
    end
    for (int i = 0; i < 64; i++) begin
      send(mk_word((i % 4) != 3), 1'b1);
      if (i == 62) begin
        checks++;
        if (ifm.good_rate !== 7'd0) begin
          fails++;
          $display("FAIL window_early: good_rate=%0d expected 0", ifm.good_rate);
        end
      end
    end
    checks++;
    if (ifm.good_rate !== 7'd48 || ifm.frame_error_count !== 20'd16 || ifm.aligned !== 1'b1) begin
      fails++;
      $display("FAIL window_rate: gr=%0d fe=%0d aligned=%b expected 48/16/1",
               ifm.good_rate, ifm.frame_error_count, ifm.aligned);
    end
    checks++;
    if (ifs.frame_error_count !== 3'h7) begin
      fails++;
      $display("FAIL saturation: narrow fe=%0d expected 7", ifs.frame_error_count);
    end
  endtask

  task automatic test_clear_and_async_reset();
    clr_counters = 1'b1;
    send(mk_word(0), 1'b1);
    clr_counters = 1'b0;
    checks++;
    if (ifm.frame_error_count !== 20'd0 || ifs.frame_error_count !== 3'd0) begin
      fails++;
      $display("FAIL clr_wins: fe=%0d narrow fe=%0d expected 0/0", ifm.frame_error_count, ifs.frame_error_count);
    end
    reset_dut();
    manual_en = 1'b1; manual_addr = 6'd5;
    idle(1);
    checks++;
    if (ifm.word_addr !== 6'd5) begin
      fails++;
      $display("FAIL manual_load: addr=%0d expected 5", ifm.word_addr);
    end
    for (int i = 0; i < 7; i++) send(mk_word(1), 1'b0);
    checks++;
    if (ifm.aligned !== 1'b0 || ifm.dout === '0) begin
      fails++;
      $display("FAIL verify_state: aligned=%b dout=%h expected 0 and nonzero", ifm.aligned, ifm.dout);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({ifm.word_addr, ifm.aligned, ifm.dout, ifm.dout_valid, ifm.frame_error_count,
         ifm.unlock_count, ifm.slip_count, ifm.good_rate} !== '0) begin
      fails++;
      $display("FAIL async_reset: addr=%0d aligned=%b dout=%h dv=%b, expected all 0",
               ifm.word_addr, ifm.aligned, ifm.dout, ifm.dout_valid);
    end
    manual_en = 1'b0;
  endtask

  task automatic test_auto_slip();
    reset_dut();
    for (int i = 0; i < 7 * 84; i++) begin
      send(mk_word(ifm.word_addr == 6'd7), 1'b0);
      if (i == 83) begin
        checks++;
        if (ifm.word_addr !== 6'd1 || ifm.slip_count !== 20'd1) begin
          fails++;
          $display("FAIL first_slip: addr=%0d slips=%0d expected 1/1", ifm.word_addr, ifm.slip_count);
        end
      end
    end
    checks++;
    if (ifm.word_addr !== 6'd7 || ifm.slip_count !== 20'd7 || ifm.aligned !== 1'b0) begin
      fails++;
      $display("FAIL slip_to_7: addr=%0d slips=%0d aligned=%b expected 7/7/0",
               ifm.word_addr, ifm.slip_count, ifm.aligned);
    end
    for (int i = 0; i < 8; i++) send(mk_word(ifm.word_addr == 6'd7), 1'b0);
    checks++;
    if (ifm.aligned !== 1'b1) begin
      fails++;
      $display("FAIL slip_lock: aligned=%b expected 1", ifm.aligned);
    end
    for (int i = 0; i < 3; i++) send(mk_word(1), 1'b1);
  endtask

  task automatic test_wrap();
    reset_dut();
    manual_en = 1'b1; manual_addr = 6'd39;
    idle(1);
    manual_en = 1'b0;
    idle(1);
    checks++;
    if (ifm.word_addr !== 6'd39) begin
      fails++;
      $display("FAIL wrap_start: addr=%0d expected 39", ifm.word_addr);
    end
    for (int i = 0; i < 4 + 2 * 84; i++) begin
      send(mk_word(ifm.word_addr == 6'd1), 1'b0);
      if (i == 87) begin
        checks++;
        if (ifm.word_addr !== 6'd0) begin
          fails++;
          $display("FAIL wrap_zero: addr=%0d expected 0", ifm.word_addr);
        end
      end
    end
    checks++;
    if (ifm.word_addr !== 6'd1 || ifm.slip_count !== 20'd2) begin
      fails++;
      $display("FAIL wrap_end: addr=%0d slips=%0d expected 1/2", ifm.word_addr, ifm.slip_count);
    end
  endtask

  task automatic test_manual_hold();
    reset_dut();
    manual_en = 1'b1; manual_addr = 6'd12;
    idle(1);
    for (int i = 0; i < 300; i++) begin
      send(mk_word(0), 1'b0);
      if (i == 99 || i == 299) begin
        checks++;
        if (ifm.word_addr !== 6'd12 || ifm.slip_count !== 20'd0 || ifm.aligned !== 1'b0) begin
          fails++;
          $display("FAIL manual_hold @%0d: addr=%0d slips=%0d aligned=%b expected 12/0/0",
                   i, ifm.word_addr, ifm.slip_count, ifm.aligned);
        end
      end
    end
    manual_addr = 6'd13;
    idle(1);
    checks++;
    if (ifm.word_addr !== 6'd13) begin
      fails++;
      $display("FAIL manual_change: addr=%0d expected 13", ifm.word_addr);
    end
    manual_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_offset0();
    test_unlock();
    test_window();
    test_clear_and_async_reset();
    test_auto_slip();
    test_wrap();
    test_manual_hold();
    reset_dut();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
